// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: encodings shared by the fetch stage and the PC-control logic
package fetch_stage_pkg;
    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_JMP = 2'd1;
    localparam logic [1:0] PCSRC_BR  = 2'd2;
    localparam logic [1:0] PCSRC_RET = 2'd3;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } fetch_state_e;
endpackage

// File: rtl/fetch_stage_pc_select.sv
// fetch_stage_pc_select: 4:1 redirect target mux
//   i_pc_src        target selector (PCSRC_* encodings)
//   i_pc_plus1      sequential PC
//   i_jump_target   jump/call target
//   i_branch_target branch target
//   i_ret_addr      return address
//   o_pc_next       selected target
module fetch_stage_pc_select
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [1:0]      i_pc_src,
    input  logic [PC_W-1:0] i_pc_plus1,
    input  logic [PC_W-1:0] i_jump_target,
    input  logic [PC_W-1:0] i_branch_target,
    input  logic [PC_W-1:0] i_ret_addr,
    output logic [PC_W-1:0] o_pc_next
);
    assign o_pc_next = i_pc_src == PCSRC_JMP ? i_jump_target :
                       i_pc_src == PCSRC_BR  ? i_branch_target :
                       i_pc_src == PCSRC_RET ? i_ret_addr : i_pc_plus1;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, req/ack instruction fetch and IF/ID pipeline register
//   clk, rst_n          clock, async active-low reset
//   i_stall             hold PC and IF/ID (wins over kill)
//   i_kill, i_pc_src    redirect request and target selector
//   i_jump_target, i_branch_target, i_ret_addr  redirect targets
//   o_imem_req/o_imem_addr, i_imem_ack/i_imem_rdata  instruction memory handshake
//   o_if_id_instr/_pc/_pc_plus1/_valid  IF/ID register to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_W      = 16,
    parameter int                  INSTR_W   = 16,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_kill,
    input  logic [1:0]         i_pc_src,
    input  logic [PC_W-1:0]    i_jump_target,
    input  logic [PC_W-1:0]    i_branch_target,
    input  logic [PC_W-1:0]    i_ret_addr,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_if_id_instr,
    output logic [PC_W-1:0]    o_if_id_pc,
    output logic [PC_W-1:0]    o_if_id_pc_plus1,
    output logic               o_if_id_valid
);
    fetch_state_e        r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, r_req_addr, r_buf_pc;
    logic [INSTR_W-1:0]  r_buf_instr;
    logic [PC_W-1:0]     w_pc_plus1, w_target;
    logic                w_run, w_redirect, w_load_mem, w_load_buf, w_bubble;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_run      = ~i_stall;
    assign w_redirect = w_run && i_kill && r_state != S_IDLE;
    assign w_load_mem = w_run && !i_kill && r_state == S_WAIT && i_imem_ack;
    assign w_load_buf = w_run && !i_kill && r_state == S_HOLD;
    assign w_bubble   = w_run && r_state != S_IDLE && !w_load_mem && !w_load_buf;

    fetch_stage_pc_select #(.PC_W(PC_W)) u_pc_select (
        .i_pc_src       (i_pc_src),
        .i_pc_plus1     (w_pc_plus1),
        .i_jump_target  (i_jump_target),
        .i_branch_target(i_branch_target),
        .i_ret_addr     (i_ret_addr),
        .o_pc_next      (w_target)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;

    // A word acked under stall cannot be re-requested, so it is parked in S_HOLD;
    // a kill with no ack leaves a response in flight that S_DRAIN must swallow.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = i_imem_ack ? (i_stall ? S_HOLD : S_WAIT) : (w_redirect ? S_DRAIN : S_WAIT);
            S_DRAIN: w_state_nxt = i_imem_ack ? S_WAIT : S_DRAIN;
            S_HOLD:  w_state_nxt = i_stall ? S_HOLD : S_WAIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_imem_req  = r_state == S_WAIT || r_state == S_DRAIN;
        o_imem_addr = r_state == S_DRAIN ? r_req_addr : r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_req_addr       <= RESET_PC;
            r_buf_instr      <= NOP_INSTR;
            r_buf_pc         <= '0;
            o_if_id_instr    <= NOP_INSTR;
            o_if_id_pc       <= '0;
            o_if_id_pc_plus1 <= '0;
            o_if_id_valid    <= 1'b0;
        end else begin
            if (w_redirect)
                r_pc <= w_target;
            else if (w_load_mem || w_load_buf)
                r_pc <= w_pc_plus1;
            if (w_redirect && r_state == S_WAIT && !i_imem_ack)
                r_req_addr <= r_pc;
            if (i_stall && r_state == S_WAIT && i_imem_ack) begin
                r_buf_instr <= i_imem_rdata;
                r_buf_pc    <= r_pc;
            end
            if (w_load_mem) begin
                o_if_id_instr    <= i_imem_rdata;
                o_if_id_pc       <= r_pc;
                o_if_id_pc_plus1 <= w_pc_plus1;
                o_if_id_valid    <= 1'b1;
            end else if (w_load_buf) begin
                o_if_id_instr    <= r_buf_instr;
                o_if_id_pc       <= r_buf_pc;
                o_if_id_pc_plus1 <= r_buf_pc + PC_W'(1);
                o_if_id_valid    <= 1'b1;
            end else if (w_bubble) begin
                o_if_id_instr    <= NOP_INSTR;
                o_if_id_valid    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-programmable memory
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  pc_src = 2'd0;
    logic [15:0] jt = '0, bt = '0, ra = '0;
    logic        req, ack, valid;
    logic [15:0] addr, rdata, instr, pc, pc1;
    logic        force_ack = 1'b0;
    int          lat = 0;
    int          cnt = 0;
    int          checks = 0;
    int          failures = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_stall         (stall),
        .i_kill          (kill),
        .i_pc_src        (pc_src),
        .i_jump_target   (jt),
        .i_branch_target (bt),
        .i_ret_addr      (ra),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_rdata    (rdata),
        .o_if_id_instr   (instr),
        .o_if_id_pc      (pc),
        .o_if_id_pc_plus1(pc1),
        .o_if_id_valid   (valid)
    );

    always #5 clk = ~clk;

    // mem[i] = 16'h1000 + i; ack arrives lat cycles after the request starts
    assign ack   = (req && cnt == lat) || force_ack;
    assign rdata = 16'h1000 + addr;
    always @(posedge clk) cnt <= (!req || ack) ? 0 : cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0000);
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_pc1", 32'(pc1), 32'h0000);
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("idle_valid", 32'(valid), 32'd0);
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", 32'(addr), 32'h0000);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_instr", 32'(instr), 32'h1000 + 32'(i));
            chk("seq_valid", 32'(valid), 32'd1);
        end
        // stall while a 2-cycle-latency fetch of addr 4 completes
        lat = 2; stall = 1'b1;
        tick; chk("stall_hold_pc_a", 32'(pc), 32'h3);
        tick; chk("stall_hold_pc_b", 32'(pc), 32'h3);
        tick; chk("hold_req", 32'(req), 32'd0);
        chk("stall_hold_pc_c", 32'(pc), 32'h3);
        chk("stall_hold_valid", 32'(valid), 32'd1);
        stall = 1'b0;
        tick; chk("release_pc", 32'(pc), 32'h4);
        chk("release_instr", 32'(instr), 32'h1004);
        chk("release_valid", 32'(valid), 32'd1);
        chk("release_addr", 32'(addr), 32'h5);
        tick; chk("lat_bubble_a", 32'(valid), 32'd0);
        chk("lat_bubble_instr", 32'(instr), 32'h0000);
        tick; chk("lat_bubble_b", 32'(valid), 32'd0);
        tick; chk("after_pc", 32'(pc), 32'h5);
        chk("after_instr", 32'(instr), 32'h1005);
        // kill with a 3-cycle fetch of addr 6 outstanding
        lat = 3; kill = 1'b1; pc_src = 2'd2; bt = 16'h0040;
        tick; kill = 1'b0; pc_src = 2'd0;
        chk("kill_valid", 32'(valid), 32'd0);
        chk("drain_addr", 32'(addr), 32'h6);
        chk("drain_req", 32'(req), 32'd1);
        tick; tick;
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_addr_b", 32'(addr), 32'h6);
        tick;
        chk("redirect_addr", 32'(addr), 32'h0040);
        chk("redirect_valid", 32'(valid), 32'd0);
        lat = 0;
        tick; chk("br_pc", 32'(pc), 32'h0040);
        chk("br_instr", 32'(instr), 32'h1040);
        chk("br_valid", 32'(valid), 32'd1);
        // stall and kill together: stall wins
        stall = 1'b1; kill = 1'b1; pc_src = 2'd3; ra = 16'h0123;
        tick; chk("sk_pc", 32'(pc), 32'h0040);
        chk("sk_req", 32'(req), 32'd0);
        chk("sk_addr", 32'(addr), 32'h0041);
        stall = 1'b0;
        tick; kill = 1'b0;
        chk("ret_bubble", 32'(valid), 32'd0);
        chk("ret_addr", 32'(addr), 32'h0123);
        tick; chk("ret_pc", 32'(pc), 32'h0123);
        chk("ret_instr", 32'(instr), 32'h1123);
        chk("ret_pc1", 32'(pc1), 32'h0124);
        // wrap at 16'hFFFF
        kill = 1'b1; pc_src = 2'd1; jt = 16'hFFFF;
        tick; kill = 1'b0; pc_src = 2'd0;
        chk("jmp_bubble", 32'(valid), 32'd0);
        chk("jmp_addr", 32'(addr), 32'hFFFF);
        tick; chk("wrap_pc", 32'(pc), 32'hFFFF);
        chk("wrap_pc1", 32'(pc1), 32'h0000);
        chk("wrap_instr", 32'(instr), 32'h0FFF);
        chk("wrap_addr", 32'(addr), 32'h0000);
        // reset mid-fetch, ack arrives while in reset and in the idle cycle
        lat = 2;
        tick; chk("mid_req", 32'(req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'h0000);
        chk("arst_pc", 32'(pc), 32'h0000);
        chk("arst_pc1", 32'(pc1), 32'h0000);
        force_ack = 1'b1;
        tick; rst_n = 1'b1;
        tick;
        chk("ign_valid", 32'(valid), 32'd0);
        chk("ign_instr", 32'(instr), 32'h0000);
        chk("post_req", 32'(req), 32'd1);
        chk("post_addr", 32'(addr), 32'h0000);
        force_ack = 1'b0; lat = 0;
        tick; chk("post_pc", 32'(pc), 32'h0000);
        chk("post_instr", 32'(instr), 32'h1000);
        chk("post_valid", 32'(valid), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
